// File: rtl/imem_load_arbiter.sv
// Arbitrates one instruction-memory port between pipeline fetch and a program loader.
// Optional stall statistics are enabled by defining IMEM_ARB_STATS_EN.
module imem_load_arbiter #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [31:0]       f_instr,
  output logic              f_valid,
  output logic              f_stall,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_overflow,
  output logic              pc_restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RESTART = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_cnt_nxt;
  logic              ovf_nxt;
  logic [31:0]       instr_nxt;
  logic              valid_nxt;

  // Memory port ownership and next-state decode; reset masks every strobe.
  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    ovf_nxt    = ld_overflow;
    instr_nxt  = f_instr;
    valid_nxt  = 1'b0;
    mem_addr   = f_addr;
    mem_wdata  = ld_data;
    mem_we     = 1'b0;
    ld_ready   = 1'b0;
    ld_busy    = 1'b0;
    f_stall    = 1'b0;
    pc_restart = 1'b0;

    case (state)
      RUN: begin
        if (f_req) begin
          instr_nxt = mem_rdata;
          valid_nxt = 1'b1;
        end
        if (ld_start) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = ld_base;
          ovf_nxt    = 1'b0;
        end
      end

      LOAD: begin
        f_stall   = 1'b1;
        ld_busy   = 1'b1;
        ld_ready  = 1'b1;
        mem_addr  = wr_cnt;
        mem_we    = ld_valid;
        instr_nxt = NOP_INSTR;
        if (ld_valid) begin
          wr_cnt_nxt = wr_cnt + 1'b1;
          if (&wr_cnt) begin
            ovf_nxt = 1'b1;
          end
          if (ld_last) begin
            state_nxt = RESTART;
          end
        end
      end

      RESTART: begin
        f_stall    = 1'b1;
        pc_restart = 1'b1;
        mem_addr   = wr_cnt;
        instr_nxt  = NOP_INSTR;
        state_nxt  = RUN;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    if (rst) begin
      mem_we     = 1'b0;
      ld_ready   = 1'b0;
      pc_restart = 1'b0;
      ld_busy    = 1'b0;
      f_stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wr_cnt      <= '0;
      f_instr     <= NOP_INSTR;
      f_valid     <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= wr_cnt_nxt;
      f_instr     <= instr_nxt;
      f_valid     <= valid_nxt;
      ld_overflow <= ovf_nxt;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the pipeline spent blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (f_stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
